calc_key_sequencer: RTL

CALC_KEY_SEQUENCER -- requirements
Module: calc_key_sequencer

---
 rtl/calc_key_sequencer_if.sv | 30 +++
 rtl/calc_key_sequencer.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/calc_key_sequencer_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | calc_key_sequencer_if : key entry, calculator and result bus bundle    |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
interface calc_key_sequencer_if;
  logic       key_valid;
  logic [4:0] key_code;
  logic       key_ready;
  logic [3:0] a;
  logic [3:0] b;
  logic [1:0] op;
  logic [7:0] calc_result;
  logic       calc_error;
  logic       res_valid;
  logic [7:0] res_data;
  logic       res_error;
  logic       res_ack;

  modport slave (
    input  key_valid, key_code, calc_result, calc_error, res_ack,
    output key_ready, a, b, op, res_valid, res_data, res_error
  );

  modport master (
    output key_valid, key_code, calc_result, calc_error, res_ack,
    input  key_ready, a, b, op, res_valid, res_data, res_error
  );
endinterface
`default_nettype wire

// File: rtl/calc_key_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | calc_key_sequencer : keypad entry of two 4-bit operands and an op,     |
// | one-cycle evaluation and held result until acknowledged. Rev 1.0      |
// +-----------------------------------------------------------------------+
module calc_key_sequencer (
  input  logic                        clk,
  input  logic                        rst_n,
  calc_key_sequencer_if.slave         bus
);

  typedef enum logic [1:0] {
    ENTER_A = 2'd0,
    ENTER_B = 2'd1,
    EVAL    = 2'd2,
    HOLD    = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] a_q, a_d;
  logic [3:0] b_q, b_d;
  logic [1:0] op_q, op_d;
  logic       ovf_q, ovf_d;
  logic       res_valid_q, res_valid_d;
  logic [7:0] res_data_q, res_data_d;
  logic       res_error_q, res_error_d;
  logic       live_q;

  logic       key_ready;
  logic       key_fire;
  logic       is_digit, is_op, is_eq, is_clr;
  logic [3:0] acc_cur;
  logic [7:0] acc_sum;
  logic [3:0] acc_sat;
  logic       acc_ovf;
  logic       eval_err;

  // live_q keeps key_ready low until the first edge after reset release
  assign key_ready = live_q && ((state_q == ENTER_A) || (state_q == ENTER_B));
  assign key_fire  = bus.key_valid && key_ready;
  assign is_digit  = !bus.key_code[4] && (bus.key_code[3:0] <= 4'd9);
  assign is_op     = (bus.key_code[4:2] == 3'b100);
  assign is_eq     = (bus.key_code == 5'h14);
  assign is_clr    = (bus.key_code == 5'h15);

  assign acc_cur  = (state_q == ENTER_B) ? b_q : a_q;
  assign acc_sum  = ({4'd0, acc_cur} * 8'd10) + {4'd0, bus.key_code[3:0]};
  assign acc_ovf  = (acc_sum > 8'd15);
  assign acc_sat  = acc_ovf ? 4'd15 : acc_sum[3:0];
  assign eval_err = bus.calc_error || ovf_q;

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    ovf_d       = ovf_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_error_d = res_error_q;
    case (state_q)
      ENTER_A: begin
        if (key_fire) begin
          if (is_digit) begin
            a_d   = acc_sat;
            ovf_d = ovf_q || acc_ovf;
          end else if (is_op) begin
            op_d    = bus.key_code[1:0];
            b_d     = 4'd0;
            state_d = ENTER_B;
          end else if (is_clr) begin
            a_d   = 4'd0;
            op_d  = 2'd0;
            ovf_d = 1'b0;
          end
        end
      end
      ENTER_B: begin
        if (key_fire) begin
          if (is_digit) begin
            b_d   = acc_sat;
            ovf_d = ovf_q || acc_ovf;
          end else if (is_op) begin
            op_d = bus.key_code[1:0];
            b_d  = 4'd0;
          end else if (is_eq) begin
            state_d = EVAL;
          end else if (is_clr) begin
            a_d     = 4'd0;
            b_d     = 4'd0;
            op_d    = 2'd0;
            ovf_d   = 1'b0;
            state_d = ENTER_A;
          end
        end
      end
      EVAL: begin
        res_valid_d = 1'b1;
        res_error_d = eval_err;
        res_data_d  = eval_err ? 8'd0 : bus.calc_result;
        state_d     = HOLD;
      end
      HOLD: begin
        if (bus.res_ack) begin
          res_valid_d = 1'b0;
          a_d         = 4'd0;
          b_d         = 4'd0;
          op_d        = 2'd0;
          ovf_d       = 1'b0;
          state_d     = ENTER_A;
        end
      end
      default: state_d = ENTER_A;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ENTER_A;
      a_q         <= 4'd0;
      b_q         <= 4'd0;
      op_q        <= 2'd0;
      ovf_q       <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= 8'd0;
      res_error_q <= 1'b0;
      live_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      ovf_q       <= ovf_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_error_q <= res_error_d;
      live_q      <= 1'b1;
    end
  end

  assign bus.key_ready = key_ready;
  assign bus.a         = a_q;
  assign bus.b         = b_q;
  assign bus.op        = op_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_error = res_error_q;

endmodule
`default_nettype wire
